spike_replay_mux: RTL

- Upstream stage of the multiplexed column. It sits between the NUM_NET independent input networks and the single shared column.
- During each gamma cycle it captures the first-spike time of every input line of every network into a write bank.
- During the following gamma cycle it replays the captured bank onto one P-wide spike bus, interleaving networks cycle by cycle.
- The downstream replay buffer demux de-interleaves the column output using the same slot ordering.

---
 rtl/spike_replay_mux.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spike_replay_mux.sv
`default_nettype none
// ============================================================================
// Module   : spike_replay_mux
// Function : double-banked first-spike capture; replays the previous gamma
//            cycle onto one P-wide bus, interleaving networks slot by slot.
// Revision : 1.0
// ============================================================================
module spike_replay_mux #(
  parameter int NUM_NET            = 2,
  parameter int P                  = 8,
  parameter int T_WIN              = 8,
  parameter int GAMMA_CYCLE_LENGTH = 18
) (
  input  logic                                  clk,
  input  logic                                  grst,
  input  logic                                  gamma_start,
  input  logic [NUM_NET*P-1:0]                  in_spikes,
  output logic [P-1:0]                          muxed_spikes,
  output logic [$clog2(NUM_NET)-1:0]            muxed_net_id,
  output logic                                  muxed_valid,
  output logic [$clog2(GAMMA_CYCLE_LENGTH)-1:0] replay_idx,
  output logic                                  late_spike
);

  localparam int c_LINES = NUM_NET * P;
  localparam int c_SLOTS = NUM_NET * T_WIN;
  localparam int c_OFF_W = $clog2(GAMMA_CYCLE_LENGTH);
  localparam int c_T_W   = $clog2(T_WIN);
  localparam int c_NID_W = $clog2(NUM_NET);
  localparam logic [c_OFF_W-1:0] c_LAST = c_OFF_W'(GAMMA_CYCLE_LENGTH - 1);

  generate
    if ((GAMMA_CYCLE_LENGTH < c_SLOTS) || (NUM_NET < 2) ||
        ((NUM_NET & (NUM_NET - 1)) != 0)) begin : g_cfg_check
      $error("spike_replay_mux: invalid NUM_NET / GAMMA_CYCLE_LENGTH combination");
    end
  endgenerate

  logic [c_OFF_W-1:0] r_offset;
  logic               r_wsel;
  logic               r_armed;
  logic               r_primed;
  logic [c_LINES-1:0] r_valid [2];
  logic [c_T_W-1:0]   r_time  [2][c_LINES];

  logic [c_OFF_W-1:0] w_off;
  logic               w_wbank;
  logic               w_rbank;
  logic               w_armed;
  logic               w_primed;
  logic               w_cap_en;
  logic               w_replay;
  logic [c_T_W-1:0]   w_t;
  logic [c_T_W-1:0]   w_k;
  logic [c_NID_W-1:0] w_net;
  logic [c_LINES-1:0] w_take;
  logic [P-1:0]       w_rd;

  // gamma_start acts within its own cycle: offset 0, swapped banks, armed
  always_comb begin
    w_off    = gamma_start ? '0 : r_offset;
    w_wbank  = gamma_start ? ~r_wsel : r_wsel;
    w_rbank  = ~w_wbank;
    w_armed  = r_armed | gamma_start;
    w_primed = r_primed | (gamma_start & r_armed);
    w_cap_en = w_armed && (32'(w_off) < T_WIN);
    w_replay = w_primed && (32'(w_off) < c_SLOTS);
    w_t      = c_T_W'(w_off);
    w_net    = w_off[c_NID_W-1:0];
    w_k      = c_T_W'(w_off >> c_NID_W);
    w_take   = (gamma_start ? in_spikes : (in_spikes & ~r_valid[w_wbank])) &
               {c_LINES{w_cap_en}};
    late_spike = ~grst & (|(in_spikes & ~w_take));
    w_rd = '0;
    for (int nn = 0; nn < NUM_NET; nn++) begin
      for (int p = 0; p < P; p++) begin
        if (w_net == c_NID_W'(nn)) begin
          w_rd[p] = r_valid[w_rbank][nn*P+p] && (r_time[w_rbank][nn*P+p] == w_k);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_offset <= '0;
      r_wsel   <= 1'b0;
      r_armed  <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      if (gamma_start) begin
        r_offset <= c_OFF_W'(1);
        r_wsel   <= ~r_wsel;
        r_armed  <= 1'b1;
        r_primed <= w_primed;
      end else if (r_offset != c_LAST) begin
        r_offset <= r_offset + c_OFF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      for (int b = 0; b < 2; b++) begin
        r_valid[b] <= '0;
        for (int i = 0; i < c_LINES; i++) begin
          r_time[b][i] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (1'(b) == w_wbank) begin
          r_valid[b] <= (gamma_start ? '0 : r_valid[b]) | w_take;
          for (int i = 0; i < c_LINES; i++) begin
            if (w_take[i]) begin
              r_time[b][i] <= w_t;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      muxed_spikes <= '0;
      muxed_net_id <= '0;
      muxed_valid  <= 1'b0;
      replay_idx   <= '0;
    end else begin
      muxed_valid  <= w_replay;
      muxed_spikes <= w_replay ? w_rd  : '0;
      muxed_net_id <= w_replay ? w_net : '0;
      replay_idx   <= w_replay ? w_off : '0;
    end
  end

endmodule
`default_nettype wire
